// File: rtl/fpu_wb_buffer.sv
// FPU result staging FIFO between post-processing and register writeback, with sticky fflags
// accumulated only on committed results. Optional zero-latency path: define FPU_WB_BYPASS_EN.
module fpu_wb_buffer #(
  parameter int FLEN  = 64,
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [FLEN-1:0] InRes,
  input  logic [XLEN-1:0] InIntRes,
  input  logic [4:0]      InFlg,
  input  logic [4:0]      InRd,
  input  logic            InToInt,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [FLEN-1:0] OutRes,
  output logic [XLEN-1:0] OutIntRes,
  output logic [4:0]      OutRd,
  output logic            OutToInt,
  input  logic            FFlagsWrEn,
  input  logic [4:0]      FFlagsWrData,
  output logic [4:0]      FFlags
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [FLEN-1:0] r_res     [DEPTH];
  logic [XLEN-1:0] r_int_res [DEPTH];
  logic [4:0]      r_flg     [DEPTH];
  logic [4:0]      r_rd      [DEPTH];
  logic            r_to_int  [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [4:0]      r_fflags;

  logic            w_fifo_valid;
  logic            w_byp;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_pop;
  logic [4:0]      w_out_flg;

  assign InReady      = (r_count != CNT_FULL);
  assign w_fifo_valid = (r_count != '0);
  assign FFlags       = r_fflags;

  // Head selection; outputs are forced to zero whenever nothing is valid
  always_comb begin
    OutValid  = 1'b0;
    OutRes    = '0;
    OutIntRes = '0;
    OutRd     = 5'd0;
    OutToInt  = 1'b0;
    w_out_flg = 5'd0;
    w_byp     = 1'b0;
`ifdef FPU_WB_BYPASS_EN
    w_byp = ~w_fifo_valid & InValid & ~Flush;
`endif
    if (w_fifo_valid) begin
      OutValid  = 1'b1;
      OutRes    = r_res[r_rd_ptr];
      OutIntRes = r_int_res[r_rd_ptr];
      OutRd     = r_rd[r_rd_ptr];
      OutToInt  = r_to_int[r_rd_ptr];
      w_out_flg = r_flg[r_rd_ptr];
    end else if (w_byp) begin
      OutValid  = 1'b1;
      OutRes    = InRes;
      OutIntRes = InIntRes;
      OutRd     = InRd;
      OutToInt  = InToInt;
      w_out_flg = InFlg;
    end else begin
      OutValid = 1'b0;
    end
  end

  // A bypassed result that commits immediately never occupies an entry
  assign w_pop      = OutValid & OutReady & ~Flush;
  assign w_push     = InValid & InReady & ~Flush & ~(w_byp & OutReady);
  assign w_fifo_pop = w_pop & w_fifo_valid;

  // Pointers, occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fflags <= 5'd0;
    end else begin
      r_fflags <= (FFlagsWrEn ? FFlagsWrData : r_fflags) | (w_pop ? w_out_flg : 5'd0);
      if (Flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_fifo_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage, cleared on reset so no X can ever surface
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i]     <= '0;
        r_int_res[i] <= '0;
        r_flg[i]     <= 5'd0;
        r_rd[i]      <= 5'd0;
        r_to_int[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_res[r_wr_ptr]     <= InRes;
      r_int_res[r_wr_ptr] <= InIntRes;
      r_flg[r_wr_ptr]     <= InFlg;
      r_rd[r_wr_ptr]      <= InRd;
      r_to_int[r_wr_ptr]  <= InToInt;
    end
  end
endmodule
